// File: rtl/keypad_scan16.sv
// 4x4 matrix keypad scanner: rotates an active-low row drive, debounces a
// single pressed key, and shifts accepted key codes into a 4-digit value.
module keypad_scan16 #(
  parameter int unsigned SCAN_TICK      = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col,
  input  logic        clr,
  output logic [3:0]  row,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_down,
  output logic [15:0] value
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  localparam logic [15:0] TICK_LAST = 16'(SCAN_TICK - 1);
  localparam logic [7:0]  DB_TICKS  = 8'(DEBOUNCE_TICKS);

  state_t      state, state_next;
  logic [3:0]  sync1, scol;
  logic [15:0] tick_cnt;
  logic        tick;
  logic [1:0]  r, r_next;
  logic [3:0]  cap, cap_next;
  logic [7:0]  stable_cnt, stable_next;
  logic [7:0]  release_cnt, release_next;
  logic        accept;
  logic [3:0]  accept_code;

  // True when exactly one column line is pulled low.
  function automatic logic one_low(input logic [3:0] v);
    logic [3:0] x;
    x = ~v;
    return (x != 4'd0) && ((x & (x - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (!v[i]) idx = 2'(i);
    return idx;
  endfunction

  assign tick     = (tick_cnt == TICK_LAST);
  assign row      = ~(4'b0001 << r);
  assign key_down = (state == HELD);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned and infers a latch.
    state_next   = state;
    r_next       = r;
    cap_next     = cap;
    stable_next  = stable_cnt;
    release_next = release_cnt;
    accept       = 1'b0;
    accept_code  = {r, low_index(cap)};

    case (state)
      SCAN: begin
        if (tick) begin
          if (one_low(scol)) begin
            cap_next    = scol;
            stable_next = 8'd1;
            if (DB_TICKS == 8'd1) begin
              accept       = 1'b1;
              accept_code  = {r, low_index(scol)};
              release_next = 8'd0;
              state_next   = HELD;
            end else begin
              state_next = DEBOUNCE;
            end
          end else begin
            r_next = r + 2'd1;
          end
        end
      end

      DEBOUNCE: begin
        if (tick) begin
          if (scol == cap) begin
            stable_next = stable_cnt + 8'd1;
            if (stable_cnt + 8'd1 == DB_TICKS) begin
              accept       = 1'b1;
              release_next = 8'd0;
              state_next   = HELD;
            end
          end else begin
            r_next     = r + 2'd1;
            state_next = SCAN;
          end
        end
      end

      HELD: begin
        // Row stays parked on the captured key until a debounced release.
        if (tick) begin
          if (scol == 4'hF) begin
            if (release_cnt + 8'd1 == DB_TICKS) begin
              release_next = 8'd0;
              r_next       = r + 2'd1;
              state_next   = SCAN;
            end else begin
              release_next = release_cnt + 8'd1;
            end
          end else begin
            release_next = 8'd0;
          end
        end
      end

      default: state_next = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers.
    if (rst) begin
      state       <= SCAN;
      sync1       <= 4'hF;
      scol        <= 4'hF;
      tick_cnt    <= 16'd0;
      r           <= 2'd0;
      cap         <= 4'hF;
      stable_cnt  <= 8'd0;
      release_cnt <= 8'd0;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      value       <= 16'h0000;
    end else begin
      sync1       <= col;
      scol        <= sync1;
      tick_cnt    <= tick ? 16'd0 : tick_cnt + 16'd1;
      state       <= state_next;
      r           <= r_next;
      cap         <= cap_next;
      stable_cnt  <= stable_next;
      release_cnt <= release_next;
      key_valid   <= accept;
      if (accept) key_code <= accept_code;
      // Clear wins over the shift so a coincident accept still lands as 0.
      if (clr)         value <= 16'h0000;
      else if (accept) value <= {value[11:0], accept_code};
    end
  end

endmodule

// File: tb/tb_keypad_scan16.sv
// Directed bench for keypad_scan16 (SCAN_TICK=4, DEBOUNCE_TICKS=3); accepted
// keys are predicted into a scoreboard queue and matched on each key_valid.
module tb_keypad_scan16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col;
  logic        clr;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] value;

  typedef struct packed {
    logic [3:0]  code;
    logic [15:0] value;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          vcount   = 0;
  logic [15:0] exp_value = 16'h0000;
  logic [3:0]  rows_tbl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  keypad_scan16 #(.SCAN_TICK(4), .DEBOUNCE_TICKS(3)) dut (
    .clk(clk), .rst(rst), .col(col), .clr(clr), .row(row),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down),
    .value(value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every key_valid must match the oldest prediction.
  always @(negedge clk) begin
    if (key_valid) begin
      exp_t e;
      vcount++;
      check("sb_nonempty", 16'(sb.size() != 0), 16'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_code", 16'(key_code), 16'(e.code));
        check("sb_value", value, e.value);
      end
    end
  end

  // Wait for the start of a fresh dwell on the target row.
  task automatic wait_row_start(input logic [3:0] target);
    int n = 0;
    while (row == target && n < 64) begin step(); n++; end
    while (row != target && n < 64) begin step(); n++; end
    check("row_reached", 16'(row), 16'(target));
  endtask

  task automatic wait_down(input logic lvl, input int budget);
    int n = 0;
    while (key_down !== lvl && n < budget) begin step(); n++; end
    check(lvl ? "key_down_rise" : "key_down_fall", 16'(key_down), 16'(lvl));
  endtask

  function automatic logic [3:0] code_of(input logic [1:0] rr, input logic [3:0] pat);
    logic [1:0] c = 2'd0;
    for (int i = 0; i < 4; i++) if (!pat[i]) c = 2'(i);
    return {rr, c};
  endfunction

  task automatic press_accept(input logic [1:0] rr, input logic [3:0] pat);
    logic [3:0] code = code_of(rr, pat);
    exp_value = {exp_value[11:0], code};
    sb.push_back({code, exp_value});
    wait_row_start(rows_tbl[rr]);
    col = pat;
    wait_down(1'b1, 60);
    col = 4'hF;
    wait_down(1'b0, 40);
  endtask

  initial begin
    int base;
    int changes;
    logic [3:0] prev;

    rst = 1'b1; col = 4'hF; clr = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_row", 16'(row), 16'(4'b1110));
    check("rst_value", value, 16'h0000);
    check("rst_valid", 16'(key_valid), 16'd0);
    check("rst_down", 16'(key_down), 16'd0);
    check("rst_code", 16'(key_code), 16'd0);

    // Idle rotation, one row step every 4 cycles.
    for (int i = 0; i < 20; i++) begin
      check("rotate", 16'(row), 16'(rows_tbl[(i / 4) % 4]));
      step();
    end

    // Key 9 held well past debounce: one pulse, then debounced release.
    exp_value = {exp_value[11:0], 4'h9};
    sb.push_back({4'h9, exp_value});
    wait_row_start(4'b1011);
    col = 4'b1101;
    repeat (11) step();
    check("k9_not_yet", 16'(key_valid), 16'd0);
    step();
    check("k9_valid", 16'(key_valid), 16'd1);
    check("k9_code", 16'(key_code), 16'h9);
    check("k9_value", value, 16'h0009);
    check("k9_down", 16'(key_down), 16'd1);
    step();
    check("k9_pulse_end", 16'(key_valid), 16'd0);
    repeat (40) step();
    check("k9_no_repeat", 16'(vcount), 16'd1);
    check("k9_still_down", 16'(key_down), 16'd1);
    col = 4'hF;
    repeat (9) step();
    check("k9_release_hold", 16'(key_down), 16'd1);
    wait_down(1'b0, 20);
    check("k9_next_row", 16'(row), 16'(4'b0111));

    // Bounce: key drops out at the next debounce tick.
    base = vcount;
    wait_row_start(4'b1011);
    col = 4'b1101;
    repeat (4) step();
    col = 4'hF;
    repeat (3) step();
    check("bounce_row_held", 16'(row), 16'(4'b1011));
    step();
    check("bounce_resume_r3", 16'(row), 16'(4'b0111));
    check("bounce_down", 16'(key_down), 16'd0);
    repeat (20) step();
    check("bounce_no_valid", 16'(vcount), 16'(base));

    // Accept 1,2,3,4 then 5.
    press_accept(2'd0, 4'b1101);
    press_accept(2'd0, 4'b1011);
    press_accept(2'd0, 4'b0111);
    press_accept(2'd1, 4'b1110);
    check("seq_1234", value, 16'h1234);
    press_accept(2'd1, 4'b1101);
    check("seq_2345", value, 16'h2345);

    // Two columns low on every row: ignored, rotation continues.
    base = vcount;
    col = 4'b1100;
    prev = row;
    changes = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (row != prev) changes++;
      prev = row;
    end
    check("multi_changes", 16'(changes), 16'd10);
    check("multi_no_valid", 16'(vcount), 16'(base));
    check("multi_down", 16'(key_down), 16'd0);
    col = 4'hF;
    repeat (3) step();

    // clr coincident with the accepting tick: value cleared, code still updates.
    exp_value = 16'h0000;
    sb.push_back({4'h6, 16'h0000});
    wait_row_start(4'b1101);
    col = 4'b1011;
    repeat (11) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_valid", 16'(key_valid), 16'd1);
    check("clr_code", 16'(key_code), 16'h6);
    check("clr_value", value, 16'h0000);
    col = 4'hF;
    wait_down(1'b0, 40);

    // Reset mid-debounce abandons the key.
    base = vcount;
    wait_row_start(4'b1110);
    col = 4'b1110;
    repeat (5) step();
    check("mid_db_no_down", 16'(key_down), 16'd0);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    col = 4'hF;
    check("rst2_row", 16'(row), 16'(4'b1110));
    check("rst2_code", 16'(key_code), 16'd0);
    check("rst2_valid", 16'(key_valid), 16'd0);
    repeat (30) step();
    check("rst2_no_valid", 16'(vcount), 16'(base));
    check("rst2_down", 16'(key_down), 16'd0);

    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_scan16.md
KEYPAD_SCAN16 -- requirements
Module: keypad_scan16

Interface
REQ-001 Parameter SCAN_TICK, default 50000: clk cycles per row dwell (one "tick" per dwell); legal range 4..65535.
REQ-002 Parameter DEBOUNCE_TICKS, default 4: consecutive stable ticks required to accept a press or a release; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 col  input  4  keypad column sense, active-low (pulled up), asynchronous to clk.
REQ-006 clr  input  1  synchronous clear of value.
REQ-007 row  output  4  keypad row drive, active-low, exactly one bit low at all times.
REQ-008 key_code  output  4  code of the last accepted key.
REQ-009 key_valid  output  1  one-cycle pulse when a key is accepted.
REQ-010 key_down  output  1  high while an accepted key is held.
REQ-011 value  output  16  last four accepted codes, newest in [3:0]; same nibble layout as the 4-digit display input.

Function
REQ-012 col SHALL pass through a 2-flop synchronizer; "scol" denotes its output; all decisions use scol only.
REQ-013 Tick counter SHALL count 0..SCAN_TICK-1 and wrap; a tick is the cycle the counter equals SCAN_TICK-1; it runs in every state.
REQ-014 Row index r (0..3) SHALL map to row = 4'b1110, 4'b1101, 4'b1011, 4'b0111 for r = 0..3.
REQ-015 Key code SHALL be r*4 + c, where c is the index of the single low bit of scol (bit 0 = c 0).
REQ-016 FSM states: SCAN, DEBOUNCE, HELD.
REQ-017 SCAN, tick, scol has exactly one bit low: capture r and the scol pattern, row held, stable count = 1, go DEBOUNCE; if DEBOUNCE_TICKS = 1, accept immediately (REQ-019) and go HELD.
REQ-018 SCAN, tick, scol = 4'b1111 or two or more bits low: r advances (3 wraps to 0) and row updates the next cycle.
REQ-019 DEBOUNCE, tick: scol equals captured pattern -> stable count + 1; on reaching DEBOUNCE_TICKS accept: key_code <= code, key_valid pulse, value <= {value[11:0], code}, go HELD.
REQ-020 DEBOUNCE, tick, scol differs from captured pattern -> no accept, r advances, go SCAN.
REQ-021 HELD: key_down = 1; row stays on the captured row; at each tick with scol = 4'b1111 the release count increments, any other scol zeroes it; on reaching DEBOUNCE_TICKS -> r advances, go SCAN, key_down = 0 the same cycle as the state change.
REQ-022 No auto-repeat: exactly one key_valid per accepted press regardless of hold time.
REQ-023 key_valid and the key_code/value updates SHALL occur in the same cycle, registered, one cycle after the accepting tick.
REQ-024 clr SHALL set value to 16'h0000 next cycle; clr coincident with an accept: value = 16'h0000, key_code and key_valid still update.
REQ-025 key_down SHALL be 1 only in HELD.

Reset
REQ-026 rst SHALL force next cycle: state SCAN, r = 0, row = 4'b1110, key_code = 0, key_valid = 0, key_down = 0, value = 16'h0000, tick/stable/release counters = 0, synchronizer = 4'b1111.
REQ-027 rst SHALL take priority over clr and over all FSM activity; rst during DEBOUNCE or HELD SHALL abandon the key with no key_valid pulse.

Verification (SCAN_TICK = 4, DEBOUNCE_TICKS = 3)
REQ-028 Assert rst 2 cycles -> row = 4'b1110, value = 16'h0000, key_valid = 0, key_down = 0; with col = 4'b1111, row rotates 1110->1101->1011->0111->1110, one step every 4 cycles.
REQ-029 While row = 4'b1011, drive col = 4'b1101 and hold -> exactly one key_valid, key_code = 4'h9, value = 16'h0009, key_down = 1 until 3 ticks after col returns to 4'b1111.
REQ-030 Press the same key but toggle col to 4'b1111 at the second DEBOUNCE tick -> no key_valid, scanning resumes from r = 3.
REQ-031 Accept codes 1, 2, 3, 4 in sequence -> value = 16'h1234; then code 5 -> 16'h2345.
REQ-032 Drive col = 4'b1100 across all rows -> no key_valid, row keeps rotating.
REQ-033 Pulse clr in the key_valid cycle -> value = 16'h0000, key_code = new code; assert rst mid-DEBOUNCE -> no pulse, row = 4'b1110.
